cdr_loop_ctrl: RTL

//  Digital loop controller for the CDR phase-frequency detector. Gates the PFD

---
 rtl/cdr_ctrl_pkg.sv | 36 +++
 rtl/cdr_loop_ctrl_sync2_ff.sv | 25 ++
 rtl/cdr_loop_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cdr_ctrl_pkg.sv
// Shared types, default loop constants and the saturating add used by the
// CDR loop controller.
package cdr_ctrl_pkg;

    // Loop controller states; the encoding is visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } cdr_state_e;

    localparam int unsigned DEF_CTRL_W        = 10;
    localparam int unsigned DEF_CTRL_INIT     = 512;
    localparam int unsigned DEF_WIN_LOG2      = 4;
    localparam int unsigned DEF_ACQ_STEP      = 16;
    localparam int unsigned DEF_LOCK_THRESH   = 2;
    localparam int unsigned DEF_LOCK_WINS     = 4;
    localparam int unsigned DEF_UNLOCK_THRESH = 8;

    // val + delta, clamped to [0, max_val].
    function automatic int sat_add(input int val, input int delta, input int max_val);
        int sum;
        int res;
        sum = val + delta;
        if (sum < 0) begin
            res = 0;
        end else if (sum > max_val) begin
            res = max_val;
        end else begin
            res = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/cdr_loop_ctrl_sync2_ff.sv
// Two-flop synchronizer for a single asynchronous level.
//  clk   : destination clock
//  rst_n : asynchronous active-low reset
//  d     : asynchronous input
//  q     : synchronized output, two clk cycles after d
module sync2_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdr_loop_ctrl.sv
// CDR loop controller: synchronizes the PFD up/down pulses, integrates net
// phase error over fixed windows, steps the oscillator tuning word and runs
// the acquire/track/lock state machine.
//  refclk     : controller clock
//  rst_n      : asynchronous active-low reset
//  enable     : run the loop; low returns to IDLE on the next edge
//  up, down   : PFD outputs, asynchronous to refclk
//  pfd_en     : PFD data gate, high outside IDLE
//  ctrl_word  : oscillator tuning word
//  ctrl_valid : one-cycle pulse when ctrl_word changes
//  state      : IDLE=0 ACQUIRE=1 TRACK=2 LOCKED=3
//  locked     : high only in LOCKED
module cdr_loop_ctrl
    import cdr_ctrl_pkg::*;
#(
    parameter int unsigned CTRL_W        = DEF_CTRL_W,
    parameter int unsigned CTRL_INIT     = DEF_CTRL_INIT,
    parameter int unsigned WIN_LOG2      = DEF_WIN_LOG2,
    parameter int unsigned ACQ_STEP      = DEF_ACQ_STEP,
    parameter int unsigned LOCK_THRESH   = DEF_LOCK_THRESH,
    parameter int unsigned LOCK_WINS     = DEF_LOCK_WINS,
    parameter int unsigned UNLOCK_THRESH = DEF_UNLOCK_THRESH
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              up,
    input  logic              down,
    output logic              pfd_en,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              ctrl_valid,
    output logic [1:0]        state,
    output logic              locked
);

    // Two guard bits keep +/- 2**WIN_LOG2 representable without overflow.
    localparam int unsigned ACC_W    = WIN_LOG2 + 2;
    localparam int unsigned QCNT_W   = $clog2(LOCK_WINS + 1);
    localparam int unsigned CTRL_MAX = (1 << CTRL_W) - 1;

    cdr_state_e                 st_q, st_d;
    logic [WIN_LOG2-1:0]        win_q, win_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [QCNT_W-1:0]          qcnt_q, qcnt_d;
    logic signed [1:0]          prev_q, prev_d;
    logic [CTRL_W-1:0]          word_d;
    logic                       valid_d;

    logic                       up_s, dn_s;
    logic signed [ACC_W-1:0]    sample_c, err_c;
    logic [ACC_W-1:0]           mag_c;
    logic signed [1:0]          sgn_c;
    logic                       win_end_c, quiet_c, overshoot_c;
    int                         step_c, delta_c;
    logic [CTRL_W-1:0]          word_sat_c;

    sync2_ff u_sync_up (.clk(refclk), .rst_n(rst_n), .d(up),   .q(up_s));
    sync2_ff u_sync_dn (.clk(refclk), .rst_n(rst_n), .d(down), .q(dn_s));

    // Window arithmetic: err includes the sample counted this cycle.
    always_comb begin
        sample_c = '0;
        if (up_s && !dn_s) begin
            sample_c = ACC_W'(1);
        end else if (dn_s && !up_s) begin
            sample_c = '1;
        end
        err_c       = acc_q + sample_c;
        mag_c       = err_c[ACC_W-1] ? -err_c : err_c;
        sgn_c       = (err_c == '0) ? 2'sd0 : (err_c[ACC_W-1] ? -2'sd1 : 2'sd1);
        win_end_c   = (st_q != ST_IDLE) && (win_q == '1);
        quiet_c     = (mag_c <= ACC_W'(LOCK_THRESH));
        overshoot_c = (sgn_c != 2'sd0) && (prev_q == -sgn_c);
        step_c      = (st_q == ST_ACQUIRE) ? int'(ACQ_STEP) : 1;
        delta_c     = int'(sgn_c) * step_c;
        word_sat_c  = CTRL_W'(sat_add(int'(ctrl_word), delta_c, int'(CTRL_MAX)));
    end

    // Next-state and next-value logic.
    always_comb begin
        st_d    = st_q;
        win_d   = win_q;
        acc_d   = acc_q;
        qcnt_d  = qcnt_q;
        prev_d  = prev_q;
        word_d  = ctrl_word;
        valid_d = 1'b0;

        if (!enable) begin
            // Disable wins over a coincident window end; tuning word is held.
            st_d   = ST_IDLE;
            win_d  = '0;
            acc_d  = '0;
            qcnt_d = '0;
            prev_d = '0;
        end else if (st_q == ST_IDLE) begin
            st_d = ST_ACQUIRE;
        end else if (win_end_c) begin
            win_d   = '0;
            acc_d   = '0;
            word_d  = word_sat_c;
            valid_d = (word_sat_c != ctrl_word);
            if (sgn_c != 2'sd0) begin
                prev_d = sgn_c;
            end
            case (st_q)
                ST_ACQUIRE: begin
                    if (quiet_c || overshoot_c) begin
                        st_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (!quiet_c) begin
                        qcnt_d = '0;
                    end else if (qcnt_q == QCNT_W'(LOCK_WINS - 1)) begin
                        st_d   = ST_LOCKED;
                        qcnt_d = '0;
                    end else begin
                        qcnt_d = qcnt_q + QCNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (mag_c > ACC_W'(UNLOCK_THRESH)) begin
                        st_d   = ST_TRACK;
                        qcnt_d = '0;
                    end
                end
                default: ;
            endcase
        end else begin
            win_d = win_q + WIN_LOG2'(1);
            acc_d = err_c;
        end
    end

    // State and output registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            win_q      <= '0;
            acc_q      <= '0;
            qcnt_q     <= '0;
            prev_q     <= '0;
            ctrl_word  <= CTRL_W'(CTRL_INIT);
            ctrl_valid <= 1'b0;
            pfd_en     <= 1'b0;
            locked     <= 1'b0;
        end else begin
            st_q       <= st_d;
            win_q      <= win_d;
            acc_q      <= acc_d;
            qcnt_q     <= qcnt_d;
            prev_q     <= prev_d;
            ctrl_word  <= word_d;
            ctrl_valid <= valid_d;
            pfd_en     <= (st_d != ST_IDLE);
            locked     <= (st_d == ST_LOCKED);
        end
    end

    assign state = st_q;

endmodule
